// File: rtl/program_counter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// program_counter_if : redirect request in, current/next fetch address out. rev 1.0
// ---------------------------------------------------------------------------
interface program_counter_if #(
  parameter int WIDTH = 32
);
  logic             branch;
  logic [WIDTH-1:0] branch_address;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] pc_plus_step;
  logic             misaligned;

  modport master (
    output branch, branch_address,
    input  pc, pc_next, pc_plus_step, misaligned
  );

  modport slave (
    input  branch, branch_address,
    output pc, pc_next, pc_plus_step, misaligned
  );
endinterface
`default_nettype wire

// File: rtl/program_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// program_counter : Tinker fetch-address register, +STEP or word-aligned redirect. rev 1.0
// ---------------------------------------------------------------------------
module program_counter #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR = 32'h0000_2000,
  parameter int               STEP       = 4
) (
  input  wire logic          clk,
  input  wire logic          reset,
  program_counter_if.slave   bus
);
  logic [WIDTH-1:0] pc_reg;
  logic [WIDTH-1:0] seq_addr;
  logic [WIDTH-1:0] target_addr;
  logic [WIDTH-1:0] next_addr;

  assign seq_addr    = pc_reg + WIDTH'(STEP);
  // Low bits are dropped so a bad target still lands on a word boundary.
  assign target_addr = {bus.branch_address[WIDTH-1:2], 2'b00};
  assign next_addr   = bus.branch ? target_addr : seq_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg <= RESET_ADDR;
    end else begin
      pc_reg <= next_addr;
    end
  end

  assign bus.pc           = pc_reg;
  assign bus.pc_next      = next_addr;
  assign bus.pc_plus_step = seq_addr;
  assign bus.misaligned   = bus.branch & (bus.branch_address[1:0] != 2'b00);
endmodule
`default_nettype wire

// File: tb/tb_program_counter.sv
`default_nettype none
// Scoreboard bench: stimulus queues expected outputs, monitor compares at negedge.
module tb_program_counter;
  logic clk;
  logic reset;

  program_counter_if #(.WIDTH(32)) bus ();

  program_counter #(
    .WIDTH      (32),
    .RESET_ADDR (32'h0000_2000),
    .STEP       (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] nxt;
    logic [31:0] plus;
    logic        mis;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string field, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", nm, field, act, exp);
    end
  endtask

  // Monitor: the PC presents a result every cycle; compare whenever one is queued.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.name, "pc",           bus.pc,                   e.pc);
        chk(e.name, "pc_next",      bus.pc_next,              e.nxt);
        chk(e.name, "pc_plus_step", bus.pc_plus_step,         e.plus);
        chk(e.name, "misaligned",   {31'd0, bus.misaligned},  {31'd0, e.mis});
      end
    end
  end

  // One vector per cycle: drive just after the edge, expect pc from that edge.
  task automatic cyc(input string nm, input logic rst, input logic mid_rst,
                     input logic br, input logic [31:0] addr, input logic [31:0] exp_pc);
    exp_t e;
    @(posedge clk);
    #1;
    reset              = rst;
    bus.branch         = br;
    bus.branch_address = addr;
    if (mid_rst) begin
      #1;
      reset = 1'b1;
    end
    e.name = nm;
    e.pc   = exp_pc;
    e.plus = exp_pc + 32'd4;
    e.nxt  = br ? {addr[31:2], 2'b00} : exp_pc + 32'd4;
    e.mis  = br && (addr[1:0] != 2'b00);
    q.push_back(e);
  endtask

  initial begin
    reset              = 1'b1;
    bus.branch         = 1'b0;
    bus.branch_address = 32'h0;

    cyc("reset_state",   1, 0, 0, 32'h0000_0000, 32'h0000_2000);
    cyc("reset_br_held", 1, 0, 1, 32'h0000_5000, 32'h0000_2000);
    cyc("reset_hold",    1, 0, 0, 32'h0000_0000, 32'h0000_2000);
    cyc("release",       0, 0, 0, 32'h0000_0000, 32'h0000_2000);
    cyc("seq_1",         0, 0, 0, 32'h0000_0000, 32'h0000_2004);
    cyc("branch_req",    0, 0, 1, 32'h0000_3000, 32'h0000_2008);
    cyc("branch_taken",  0, 0, 0, 32'h0000_0000, 32'h0000_3000);
    cyc("misalign_req",  0, 0, 1, 32'h0000_4003, 32'h0000_3004);
    cyc("misalign_load", 0, 0, 0, 32'h0000_4003, 32'h0000_4000);
    cyc("wrap_req",      0, 0, 1, 32'hFFFF_FFFC, 32'h0000_4004);
    cyc("wrap_top",      0, 0, 0, 32'h0000_0000, 32'hFFFF_FFFC);
    cyc("wrap_zero",     0, 0, 0, 32'hxxxx_xxxx, 32'h0000_0000);
    cyc("x_addr_ignored",0, 0, 0, 32'hxxxx_xxxx, 32'h0000_0004);
    cyc("seq_after_x",   0, 0, 0, 32'h0000_0000, 32'h0000_0008);
    cyc("seq_c",         0, 0, 0, 32'h0000_0000, 32'h0000_000C);
    cyc("mid_reset",     0, 1, 0, 32'h0000_0000, 32'h0000_2000);
    cyc("reset_vs_br",   1, 0, 1, 32'h0000_5000, 32'h0000_2000);
    cyc("reset_hold_2",  1, 0, 0, 32'h0000_0000, 32'h0000_2000);
    cyc("self_loop_1",   0, 0, 1, 32'h0000_2000, 32'h0000_2000);
    cyc("self_loop_2",   0, 0, 1, 32'h0000_2000, 32'h0000_2000);
    cyc("self_loop_3",   0, 0, 1, 32'h0000_2000, 32'h0000_2000);
    cyc("loop_exit",     0, 0, 0, 32'h0000_0000, 32'h0000_2000);
    cyc("loop_advance",  0, 0, 0, 32'h0000_0000, 32'h0000_2004);

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    if (!done) begin
      $display("FAIL timeout: run did not complete, expected completion");
      $fatal(1, "timeout");
    end
  end
endmodule
`default_nettype wire

// File: doc/program_counter.md
# program_counter

Instruction-address register for the Tinker core. Holds the address of the instruction currently being fetched, advances by one 4-byte word each clock, and loads a redirect target when `branch` is asserted. It drives the instruction-memory fetch port inside `tinker_core`; all next-PC selection beyond a single taken/not-taken redirect happens upstream.

## Interface
Parameters:
- `WIDTH`, 32: address width in bits; `pc`, `branch_address` and all derived outputs use it.
- `RESET_ADDR`, 32'h0000_2000: value loaded on reset (program base); must be word-aligned.
- `STEP`, 4: sequential increment in bytes.

Ports (reset reset, asynchronous, active-high; clock clk):
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high; forces `pc` to `RESET_ADDR`.
- `branch`  input  1  redirect request, sampled at rising `clk`.
- `branch_address`  input  WIDTH  redirect target, sampled with `branch`.
- `pc`  output  WIDTH  registered current instruction address.
- `pc_next`  output  WIDTH  combinational value `pc` will take at the next edge.
- `pc_plus_step`  output  WIDTH  combinational `pc + STEP`, the return/fall-through address.
- `misaligned`  output  1  combinational: `branch` high and `branch_address[1:0] != 0`.

## Operation
- State: one WIDTH-bit register `pc`. No other state; no FSM.
- `pc_plus_step` = (`pc` + `STEP`) mod 2^WIDTH; carry discarded, so 0xFFFF_FFFC wraps to 0x0000_0000.
- `pc_next` = `branch` ? {`branch_address`[WIDTH-1:2], 2'b00} : `pc_plus_step`.
- Target alignment: low two bits of `branch_address` are forced to zero before loading; `misaligned` reports the dropped bits for that cycle. It is informational only and does not block the load.
- `branch` takes priority over sequential advance; a redirect to the current `pc` value holds the PC (self-loop).
- `branch` low: `branch_address` is ignored entirely (X on it must not propagate into `pc`).
- No stall/enable input: the PC advances on every non-reset edge.

## Timing
- Reset: on `reset` rising, `pc` becomes `RESET_ADDR` immediately, without waiting for `clk`. While `reset` is high, `pc` holds `RESET_ADDR` regardless of `clk`, `branch`, `branch_address`.
- Reset values: `pc` = 0x2000; `pc_plus_step` = 0x2004; `pc_next` = 0x2004 (or masked target if `branch` high); `misaligned` follows its inputs.
- Reset mid-operation: asserting at any time, including mid-cycle or coincident with a `clk` edge, yields `pc` = `RESET_ADDR`; reset wins over any edge.
- Reset release: first rising `clk` with `reset` low loads `pc_next` (0x2004 if not branching). No extra dead cycle.
- Latency: `branch`/`branch_address` presented before edge N appear on `pc` after edge N (one cycle). `pc_next`, `pc_plus_step`, `misaligned` are zero-latency combinational functions of `pc`, `branch`, `branch_address`.
- `pc` changes only on rising `clk` or rising `reset`; it is glitch-free between edges.

## Test plan
- Reset: assert `reset` mid-cycle with `pc` = 0x2010 -> `pc` = 0x2000 before next `clk` edge; hold reset 3 edges -> stays 0x2000.
- Sequential: release reset, `branch`=0, 4 edges -> `pc` = 0x2004, 0x2008, 0x200C, 0x2010; `pc_plus_step` always `pc`+4.
- Branch: at `pc` = 0x2008, `branch`=1, `branch_address`=0x3000 for one edge -> `pc` = 0x3000, then 0x3004 with `branch`=0; `pc_next` = 0x3000 before the edge.
- Misaligned target: `branch`=1, `branch_address`=0x4003 -> `misaligned`=1, after edge `pc` = 0x4000; `branch`=0 with same address -> `misaligned`=0, `pc` advances by 4.
- Wrap-around: branch to 0xFFFF_FFFC, then one sequential edge -> `pc` = 0x0000_0000, `pc_plus_step` = 0x0000_0004.
- Simultaneous: `reset` and `branch`=1 (`branch_address`=0x5000) at the same edge -> `pc` = 0x2000; self-loop branch to current `pc` 0x2000 for 3 edges -> `pc` stays 0x2000.
